dcache_mem_initiator: RTL and testbench
=======================================

Name: dcache_mem_initiator

Overview:
Initiator end of the write-through dcache memory interface. It accepts load/store commands from a simple command port, issues them as dcache_req_t over the mem_data_req/ack handshake with tracked transaction IDs (tid), and matches dcache_rtrn_t returns (LOAD_ACK, STORE_ACK, INV_REQ) to outstanding tids. It sits between a traffic agent or a small controller and any memory responder.

Parameters:
NumTids, 4, maximum outstanding transactions; tid width = $clog2(NumTids), minimum 1.
CachedAddrBeg, 64'h0, first cacheable physical address (inclusive).
CachedAddrEnd, 64'hFFFF_FFFF_FFFF_FFFF, end of cacheable region (exclusive).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is synchronous and active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_store_i  in  1  1=store, 0=load
cmd_size_i  in  3  transfer size code (0=B, 1=H, 2=W, 3=D)
cmd_paddr_i  in  64  physical byte address
cmd_data_i  in  64  store data, byte lanes as in memory word
mem_data_req_o  out  1  request valid
mem_data_ack_i  in  1  request accepted by responder
mem_data_o  out  dcache_req_t  request payload (rtype, size, paddr, data, nc, tid)
mem_rtrn_vld_i  in  1  return valid (no backpressure)
mem_rtrn_i  in  dcache_rtrn_t  return payload
rsp_vld_o  out  1  one-cycle completion pulse
rsp_store_o  out  1  completion was a STORE_ACK
rsp_tid_o  out  TidW  completed tid
rsp_data_o  out  DCACHE_LINE_WIDTH  load return data, raw
inv_vld_o  out  1  one-cycle invalidation pulse
inv_idx_o  out  DCACHE_INDEX_WIDTH  invalidation index
inv_all_o  out  1  invalidate all ways
outstanding_o  out  TidW+1  number of busy tids
err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_ni low at clk edge): state IDLE; busy vector 0; all outputs 0 (mem_data_o all zeros). Reset mid-transaction drops all tracking; request withdrawn next cycle.
- FSM: IDLE, REQ. IDLE: cmd_ready_o = (busy != all-ones). On accept: allocate lowest-index free tid, set its busy bit, latch payload, go REQ. REQ: mem_data_req_o=1, mem_data_o stable until mem_data_ack_i. On ack: if new command accepted same cycle -> stay REQ with new payload; else -> IDLE.
- cmd_ready_o in REQ = mem_data_ack_i & free tid exists (combinational from ack). Free tid computed from registered busy vector; a tid released this cycle is allocatable next cycle only.
- Payload mapping: store -> DCACHE_STORE_REQ, size=cmd_size_i, data=cmd_data_i. Load -> DCACHE_LOAD_REQ.
- nc = 1 when paddr < CachedAddrBeg or paddr >= CachedAddrEnd.
- Cached load: size forced 3'b111, paddr aligned down to DCACHE_LINE_WIDTH/8 bytes. nc load/store: size and paddr unchanged.
- Illegal command (cmd_size_i > 3): consumed (ready as normal), no tid allocated, no request issued, err_o set.
- Returns, registered, outputs pulse cycle after mem_rtrn_vld_i:
  LOAD_ACK/STORE_ACK with busy tid -> clear busy bit, rsp_vld_o=1, rsp_tid_o=tid, rsp_store_o=(STORE_ACK), rsp_data_o=mem_rtrn_i.data for loads, 0 for stores.
  INV_REQ -> inv_vld_o=1, inv_idx_o, inv_all_o from mem_rtrn_i.inv; no tid effect.
  ACK with non-busy tid, or any other rtype -> err_o set, no pulse.
- Same-cycle allocate and release of different tids both take effect; outstanding_o = popcount(busy), updated every cycle.
- err_o clears only on reset.

Test Plan:
- Cached load paddr 0x1234, CachedAddrBeg=0 -> mem_data_o.size=3'b111, paddr=0x1200 (512-bit line: 0x1234 & ~0x3F = 0x1200), nc=0, tid=0; LOAD_ACK tid 0 data D -> rsp_vld_o cycle after, rsp_data_o=D, outstanding_o 1->0.
- CachedAddrBeg=0x1000, store size 0 paddr 0x10 data 0xAB -> nc=1, size=0, rtype STORE_REQ; STORE_ACK -> rsp_store_o=1.
- 5 loads, NumTids=4, no returns -> tids 0,1,2,3 issued, cmd_ready_o low for 5th; return tid 2 -> 5th issued with tid 2 next cycle.
- Responder holds ack low 7 cycles -> mem_data_req_o high and mem_data_o bit-identical all 7 cycles; ack with cmd_valid_i high -> back-to-back request next cycle.
- INV_REQ idx 0x15 all=1 -> inv_vld_o one cycle, inv_idx_o=0x15; LOAD_ACK tid 3 while idle -> err_o=1, no rsp_vld_o.
- Reset asserted during REQ -> next cycle mem_data_req_o=0, outstanding_o=0, err_o=0.

Source files
------------

// File: rtl/dcache_mem_pkg.sv
// Shared request/return types for the write-through dcache memory interface.
package dcache_mem_pkg;

   localparam int unsigned DCACHE_LINE_WIDTH  = 512;
   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_TID_WIDTH   = 8;

   typedef enum logic [1:0] {
      DCACHE_LOAD_REQ  = 2'd0,
      DCACHE_STORE_REQ = 2'd1,
      DCACHE_ATOP_REQ  = 2'd2,
      DCACHE_INT_REQ   = 2'd3
   } dcache_out_t;

   typedef enum logic [2:0] {
      DCACHE_INV_REQ   = 3'd0,
      DCACHE_LOAD_ACK  = 3'd1,
      DCACHE_STORE_ACK = 3'd2,
      DCACHE_ATOP_ACK  = 3'd3,
      DCACHE_INT_ACK   = 3'd4
   } dcache_in_t;

   typedef struct packed {
      logic                          vld;
      logic                          all;
      logic [DCACHE_INDEX_WIDTH-1:0] idx;
   } dcache_inval_t;

   typedef struct packed {
      dcache_out_t                 rtype;
      logic [2:0]                  size;
      logic [63:0]                 paddr;
      logic [63:0]                 data;
      logic                        nc;
      logic [DCACHE_TID_WIDTH-1:0] tid;
   } dcache_req_t;

   typedef struct packed {
      dcache_in_t                   rtype;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      dcache_inval_t                inv;
      logic [DCACHE_TID_WIDTH-1:0]  tid;
   } dcache_rtrn_t;

endpackage

// File: rtl/dcache_mem_initiator.sv
// Initiator side of the dcache memory interface: issues load/store requests
// with tracked tids and matches returned acks/invalidations against them.
module dcache_mem_initiator
   import dcache_mem_pkg::*;
#(
   parameter int unsigned NumTids       = 4,
   parameter logic [63:0] CachedAddrBeg = 64'h0,
   parameter logic [63:0] CachedAddrEnd = 64'hFFFF_FFFF_FFFF_FFFF,
   localparam int unsigned TidW         = (NumTids > 1) ? $clog2(NumTids) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic                          cmd_store_i,
   input  logic [2:0]                    cmd_size_i,
   input  logic [63:0]                   cmd_paddr_i,
   input  logic [63:0]                   cmd_data_i,
   output logic                          mem_data_req_o,
   input  logic                          mem_data_ack_i,
   output dcache_req_t                   mem_data_o,
   input  logic                          mem_rtrn_vld_i,
   input  dcache_rtrn_t                  mem_rtrn_i,
   output logic                          rsp_vld_o,
   output logic                          rsp_store_o,
   output logic [TidW-1:0]               rsp_tid_o,
   output logic [DCACHE_LINE_WIDTH-1:0]  rsp_data_o,
   output logic                          inv_vld_o,
   output logic [DCACHE_INDEX_WIDTH-1:0] inv_idx_o,
   output logic                          inv_all_o,
   output logic [TidW:0]                 outstanding_o,
   output logic                          err_o
);

   localparam logic [63:0] LineMask = ~(64'(DCACHE_LINE_WIDTH / 8) - 64'd1);

   typedef enum logic {IDLE, REQ} state_e;

   state_e             state_q, state_d;
   logic [NumTids-1:0] busy_q, alloc_vec, rel_vec;
   logic               free_avail;
   logic [TidW-1:0]    free_tid;
   logic               accept, issue, illegal;
   dcache_req_t        req_q, req_new;
   logic               nc;
   logic               is_ack, tid_in_range, ack_ok, rtrn_bad;
   logic [TidW-1:0]    rtrn_tid;

   // Lowest-index free tid, from the registered busy vector only.
   always_comb begin
      free_tid = '0;
      for (int unsigned i = NumTids; i > 0; i--) begin
         if (!busy_q[i-1]) free_tid = TidW'(i - 1);
      end
   end

   assign free_avail = ~&busy_q;

   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      case (state_q)
         IDLE: cmd_ready_o = rst_ni & free_avail;
         REQ:  cmd_ready_o = rst_ni & mem_data_ack_i & free_avail;
         default: ;
      endcase
      accept  = cmd_valid_i & cmd_ready_o;
      illegal = accept & cmd_size_i[2];
      issue   = accept & ~cmd_size_i[2];
      case (state_q)
         IDLE: if (issue) state_d = REQ;
         REQ:  if (mem_data_ack_i) state_d = issue ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      nc            = (cmd_paddr_i < CachedAddrBeg) || (cmd_paddr_i >= CachedAddrEnd);
      req_new       = '0;
      req_new.nc    = nc;
      req_new.tid   = DCACHE_TID_WIDTH'(free_tid);
      req_new.size  = cmd_size_i;
      req_new.paddr = cmd_paddr_i;
      if (cmd_store_i) begin
         req_new.rtype = DCACHE_STORE_REQ;
         req_new.data  = cmd_data_i;
      end else begin
         req_new.rtype = DCACHE_LOAD_REQ;
         // Cached loads always fetch a whole line.
         if (!nc) begin
            req_new.size  = 3'b111;
            req_new.paddr = cmd_paddr_i & LineMask;
         end
      end
   end

   always_comb begin
      rtrn_tid     = mem_rtrn_i.tid[TidW-1:0];
      is_ack       = (mem_rtrn_i.rtype == DCACHE_LOAD_ACK) || (mem_rtrn_i.rtype == DCACHE_STORE_ACK);
      tid_in_range = 32'(mem_rtrn_i.tid) < NumTids;
      ack_ok       = mem_rtrn_vld_i & is_ack & tid_in_range & busy_q[rtrn_tid];
      rtrn_bad     = mem_rtrn_vld_i & ~ack_ok & (mem_rtrn_i.rtype != DCACHE_INV_REQ);
      alloc_vec    = '0;
      rel_vec      = '0;
      if (issue)  alloc_vec[free_tid] = 1'b1;
      if (ack_ok) rel_vec[rtrn_tid]   = 1'b1;
   end

   always_comb begin
      outstanding_o = '0;
      for (int unsigned i = 0; i < NumTids; i++) begin
         outstanding_o = outstanding_o + {{TidW{1'b0}}, busy_q[i]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q      <= '0;
         req_q       <= '0;
         rsp_vld_o   <= 1'b0;
         rsp_store_o <= 1'b0;
         rsp_tid_o   <= '0;
         rsp_data_o  <= '0;
         inv_vld_o   <= 1'b0;
         inv_idx_o   <= '0;
         inv_all_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         busy_q    <= (busy_q & ~rel_vec) | alloc_vec;
         err_o     <= err_o | illegal | rtrn_bad;
         rsp_vld_o <= ack_ok;
         inv_vld_o <= mem_rtrn_vld_i & (mem_rtrn_i.rtype == DCACHE_INV_REQ);
         if (issue) req_q <= req_new;
         if (ack_ok) begin
            rsp_store_o <= (mem_rtrn_i.rtype == DCACHE_STORE_ACK);
            rsp_tid_o   <= rtrn_tid;
            rsp_data_o  <= (mem_rtrn_i.rtype == DCACHE_LOAD_ACK) ? mem_rtrn_i.data : '0;
         end
         if (mem_rtrn_vld_i && mem_rtrn_i.rtype == DCACHE_INV_REQ) begin
            inv_idx_o <= mem_rtrn_i.inv.idx;
            inv_all_o <= mem_rtrn_i.inv.all;
         end
      end
   end

   assign mem_data_req_o = (state_q == REQ);
   assign mem_data_o     = req_q;

endmodule

// File: tb/tb_dcache_mem_initiator.sv
// Directed bench for dcache_mem_initiator: cycle table plus corner sequences.
module tb_dcache_mem_initiator;
   import dcache_mem_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         cmd_valid, cmd_store, ack, rtrn_vld;
   logic [2:0]   cmd_size;
   logic [63:0]  cmd_paddr, cmd_data;
   dcache_rtrn_t rtrn;

   logic         rdy_a, req_a, rsp_vld_a, rsp_store_a, inv_vld_a, inv_all_a, err_a;
   dcache_req_t  mem_a;
   logic [1:0]   rsp_tid_a;
   logic [511:0] rsp_data_a;
   logic [11:0]  inv_idx_a;
   logic [2:0]   out_a;

   logic         rdy_b, req_b, rsp_vld_b, rsp_store_b, inv_vld_b, inv_all_b, err_b;
   dcache_req_t  mem_b;
   logic [1:0]   rsp_tid_b;
   logic [511:0] rsp_data_b;
   logic [11:0]  inv_idx_b;
   logic [2:0]   out_b;

   dcache_mem_initiator #(.NumTids(4), .CachedAddrBeg(64'h0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy_a), .cmd_store_i(cmd_store),
      .cmd_size_i(cmd_size), .cmd_paddr_i(cmd_paddr), .cmd_data_i(cmd_data),
      .mem_data_req_o(req_a), .mem_data_ack_i(ack), .mem_data_o(mem_a),
      .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_i(rtrn),
      .rsp_vld_o(rsp_vld_a), .rsp_store_o(rsp_store_a), .rsp_tid_o(rsp_tid_a),
      .rsp_data_o(rsp_data_a), .inv_vld_o(inv_vld_a), .inv_idx_o(inv_idx_a),
      .inv_all_o(inv_all_a), .outstanding_o(out_a), .err_o(err_a)
   );

   // Second instance with a non-cacheable low region; otherwise identical.
   dcache_mem_initiator #(.NumTids(4), .CachedAddrBeg(64'h1000)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy_b), .cmd_store_i(cmd_store),
      .cmd_size_i(cmd_size), .cmd_paddr_i(cmd_paddr), .cmd_data_i(cmd_data),
      .mem_data_req_o(req_b), .mem_data_ack_i(ack), .mem_data_o(mem_b),
      .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_i(rtrn),
      .rsp_vld_o(rsp_vld_b), .rsp_store_o(rsp_store_b), .rsp_tid_o(rsp_tid_b),
      .rsp_data_o(rsp_data_b), .inv_vld_o(inv_vld_b), .inv_idx_o(inv_idx_b),
      .inv_all_o(inv_all_b), .outstanding_o(out_b), .err_o(err_b)
   );

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [511:0] LineData = {8{64'hA5A5_0F0F_1234_5678}};

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0; cmd_store = 1'b0; cmd_size = 3'd0;
      cmd_paddr = '0;   cmd_data = '0;    ack = 1'b0;
      rtrn_vld = 1'b0;  rtrn = '0;
   endtask

   task automatic drive_cmd(input logic st, input logic [2:0] sz, input logic [63:0] pa, input logic [63:0] d);
      cmd_valid = 1'b1; cmd_store = st; cmd_size = sz; cmd_paddr = pa; cmd_data = d;
   endtask

   task automatic drive_rtrn(input dcache_in_t rt, input logic [7:0] tid);
      rtrn_vld      = 1'b1;
      rtrn          = '0;
      rtrn.rtype    = rt;
      rtrn.tid      = tid;
      rtrn.data     = LineData;
      rtrn.inv.idx  = 12'h15;
      rtrn.inv.all  = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic dcache_req_t mk_req(input dcache_out_t rt, input logic [2:0] sz,
                                          input logic [63:0] pa, input logic [63:0] d,
                                          input logic nc, input logic [7:0] tid);
      dcache_req_t r;
      r = '0;
      r.rtype = rt; r.size = sz; r.paddr = pa; r.data = d; r.nc = nc; r.tid = tid;
      return r;
   endfunction

   typedef struct {
      logic        v;
      logic [63:0] addr;
      logic        ack;
      logic        rv;
      dcache_in_t  rt;
      logic [1:0]  rtid;
      logic        e_rdy;
      logic        e_req;
      logic [1:0]  e_tid;
      logic [2:0]  e_out;
      logic        e_rsp;
      logic [1:0]  e_rsp_tid;
      logic        e_inv;
      logic        e_err;
   } vec_t;

   function automatic vec_t row(input logic v, input logic [63:0] addr, input logic a,
                                input logic rv, input dcache_in_t rt, input logic [1:0] rtid,
                                input logic e_rdy, input logic e_req, input logic [1:0] e_tid,
                                input logic [2:0] e_out, input logic e_rsp, input logic [1:0] e_rsp_tid,
                                input logic e_inv, input logic e_err);
      vec_t r;
      r.v = v; r.addr = addr; r.ack = a; r.rv = rv; r.rt = rt; r.rtid = rtid;
      r.e_rdy = e_rdy; r.e_req = e_req; r.e_tid = e_tid; r.e_out = e_out;
      r.e_rsp = e_rsp; r.e_rsp_tid = e_rsp_tid; r.e_inv = e_inv; r.e_err = e_err;
      return r;
   endfunction

   vec_t        tbl [26];
   dcache_req_t exp_a, exp_b;

   initial begin
      // Each row is one cycle: loads only; outputs as seen during that cycle.
      //            v  addr       ack rv rtype             rt rdy req tid out rsp rt inv err
      tbl[0]  = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = row(1, 64'h1234,  0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 0, 1, 0, 1, 0, 0, 0, 0);
      tbl[3]  = row(0, 64'h0,     1, 0, DCACHE_INV_REQ,   0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[4]  = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  0, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[5]  = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[6]  = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = row(1, 64'h100,   0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = row(1, 64'h140,   1, 0, DCACHE_INV_REQ,   0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[9]  = row(1, 64'h180,   1, 0, DCACHE_INV_REQ,   0, 1, 1, 1, 2, 0, 0, 0, 0);
      tbl[10] = row(1, 64'h1C0,   1, 0, DCACHE_INV_REQ,   0, 1, 1, 2, 3, 0, 0, 0, 0);
      tbl[11] = row(1, 64'h200,   1, 0, DCACHE_INV_REQ,   0, 0, 1, 3, 4, 0, 0, 0, 0);
      tbl[12] = row(1, 64'h200,   0, 0, DCACHE_INV_REQ,   0, 0, 0, 0, 4, 0, 0, 0, 0);
      tbl[13] = row(1, 64'h200,   0, 1, DCACHE_LOAD_ACK,  2, 0, 0, 0, 4, 0, 0, 0, 0);
      tbl[14] = row(1, 64'h200,   0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 3, 1, 2, 0, 0);
      tbl[15] = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 0, 1, 2, 4, 0, 0, 0, 0);
      tbl[16] = row(0, 64'h0,     1, 0, DCACHE_INV_REQ,   0, 0, 1, 2, 4, 0, 0, 0, 0);
      tbl[17] = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  0, 0, 0, 0, 4, 0, 0, 0, 0);
      tbl[18] = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  1, 1, 0, 0, 3, 1, 0, 0, 0);
      tbl[19] = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  2, 1, 0, 0, 2, 1, 1, 0, 0);
      tbl[20] = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  3, 1, 0, 0, 1, 1, 2, 0, 0);
      tbl[21] = row(0, 64'h0,     0, 1, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 1, 3, 0, 0);
      tbl[22] = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl[23] = row(0, 64'h0,     0, 1, DCACHE_LOAD_ACK,  3, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[24] = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 1);
      tbl[25] = row(0, 64'h0,     0, 0, DCACHE_INV_REQ,   0, 1, 0, 0, 0, 0, 0, 0, 1);

      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();
      #1;
      chk("reset_payload", mem_a, '0);
      chk("reset_rsp_data", rsp_data_a, '0);

      for (int i = 0; i < 26; i++) begin
         idle_inputs();
         if (tbl[i].v) drive_cmd(1'b0, 3'd3, tbl[i].addr, 64'h0);
         ack = tbl[i].ack;
         if (tbl[i].rv) drive_rtrn(tbl[i].rt, 8'(tbl[i].rtid));
         #1;
         chk($sformatf("v%0d_ready", i), rdy_a, tbl[i].e_rdy);
         chk($sformatf("v%0d_req", i), req_a, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("v%0d_tid", i), mem_a.tid, tbl[i].e_tid);
         chk($sformatf("v%0d_outstanding", i), out_a, tbl[i].e_out);
         chk($sformatf("v%0d_rsp_vld", i), rsp_vld_a, tbl[i].e_rsp);
         if (tbl[i].e_rsp) chk($sformatf("v%0d_rsp_tid", i), rsp_tid_a, tbl[i].e_rsp_tid);
         chk($sformatf("v%0d_inv_vld", i), inv_vld_a, tbl[i].e_inv);
         if (tbl[i].e_inv) begin
            chk($sformatf("v%0d_inv_idx", i), inv_idx_a, 12'h15);
            chk($sformatf("v%0d_inv_all", i), inv_all_a, 1'b1);
         end
         chk($sformatf("v%0d_err", i), err_a, tbl[i].e_err);
         tick();
      end

      // Cached load payload and raw line return.
      do_reset();
      drive_cmd(1'b0, 3'd2, 64'h1234, 64'h0);
      tick();
      idle_inputs();
      #1;
      exp_a = mk_req(DCACHE_LOAD_REQ, 3'b111, 64'h1200, 64'h0, 1'b0, 8'd0);
      chk("cached_load_a", mem_a, exp_a);
      chk("cached_load_b", mem_b, exp_a);
      ack = 1'b1;
      tick();
      idle_inputs();
      drive_rtrn(DCACHE_LOAD_ACK, 8'd0);
      tick();
      idle_inputs();
      #1;
      chk("load_rsp_vld", rsp_vld_a, 1'b1);
      chk("load_rsp_store", rsp_store_a, 1'b0);
      chk("load_rsp_data", rsp_data_a, LineData);
      chk("load_outstanding", out_a, 3'd0);

      // Byte store, non-cacheable only in the second instance.
      drive_cmd(1'b1, 3'd0, 64'h10, 64'hAB);
      tick();
      idle_inputs();
      #1;
      exp_a = mk_req(DCACHE_STORE_REQ, 3'd0, 64'h10, 64'hAB, 1'b0, 8'd0);
      exp_b = mk_req(DCACHE_STORE_REQ, 3'd0, 64'h10, 64'hAB, 1'b1, 8'd0);
      chk("store_payload_a", mem_a, exp_a);
      chk("store_payload_b", mem_b, exp_b);
      ack = 1'b1;
      tick();
      idle_inputs();
      drive_rtrn(DCACHE_STORE_ACK, 8'd0);
      tick();
      idle_inputs();
      #1;
      chk("store_rsp_vld", rsp_vld_b, 1'b1);
      chk("store_rsp_store", rsp_store_b, 1'b1);
      chk("store_rsp_data", rsp_data_b, '0);

      // Request held stable while ack stays low, then back-to-back issue.
      drive_cmd(1'b0, 3'd3, 64'h2008, 64'h0);
      tick();
      idle_inputs();
      exp_a = mk_req(DCACHE_LOAD_REQ, 3'b111, 64'h2000, 64'h0, 1'b0, 8'd0);
      for (int c = 0; c < 7; c++) begin
         #1;
         chk($sformatf("hold%0d_req", c), req_a, 1'b1);
         chk($sformatf("hold%0d_payload", c), mem_a, exp_a);
         tick();
      end
      ack = 1'b1;
      drive_cmd(1'b0, 3'd3, 64'h40, 64'h0);
      #1;
      chk("b2b_ready", rdy_a, 1'b1);
      tick();
      idle_inputs();
      #1;
      chk("b2b_req", req_a, 1'b1);
      chk("b2b_payload", mem_a, mk_req(DCACHE_LOAD_REQ, 3'b111, 64'h40, 64'h0, 1'b0, 8'd1));
      chk("b2b_outstanding", out_a, 3'd2);
      ack = 1'b1;
      tick();
      idle_inputs();
      drive_rtrn(DCACHE_LOAD_ACK, 8'd0);
      tick();
      drive_rtrn(DCACHE_LOAD_ACK, 8'd1);
      tick();
      idle_inputs();
      #1;
      chk("drain_outstanding", out_a, 3'd0);

      // Illegal size: consumed, nothing issued, sticky error.
      drive_cmd(1'b1, 3'd4, 64'h80, 64'h1);
      #1;
      chk("illegal_ready", rdy_a, 1'b1);
      chk("illegal_pre_err", err_a, 1'b0);
      tick();
      idle_inputs();
      #1;
      chk("illegal_req", req_a, 1'b0);
      chk("illegal_outstanding", out_a, 3'd0);
      chk("illegal_err", err_a, 1'b1);

      // Reset while a request is pending drops everything.
      drive_cmd(1'b0, 3'd3, 64'h300, 64'h0);
      tick();
      idle_inputs();
      #1;
      chk("prerst_req", req_a, 1'b1);
      chk("prerst_outstanding", out_a, 3'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_req", req_a, 1'b0);
      chk("rst_outstanding", out_a, 3'd0);
      chk("rst_err", err_a, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
